seg7_scan_driver: RTL

- Display-side consumer of the stopwatch outputs: takes the four BCD digits plus is_adj/is_sel_sec and drives a 4-digit, common-anode, time-multiplexed 7-segment display.
- Scans one digit at a time with an anti-ghosting blank interval.
- Shows a decimal-point separator between minutes and seconds.
- In adjust mode, blinks the selected field (minutes or seconds), paced by the clk_2hz pulse.

---
 rtl/seg7_scan_driver_pkg.sv | 50 +++++
 rtl/seg7_scan_driver_bcd_to_seg7.sv | 33 +++
 rtl/seg7_scan_driver.sv | 130 +++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_pkg.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver_pkg
//   Shared definitions for the 4-digit multiplexed 7-segment driver:
//   active-low glyph constants, anode constants, digit slot indices, the
//   registered display word and a small anode-select helper.
//   This package is the single home for the display constants; every file
//   of the driver imports it rather than repeating literals.
// ---------------------------------------------------------------------------
package seg7_scan_driver_pkg;

   // Segment order is {g,f,e,d,c,b,a}. A segment lights when its bit is 0.
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // All anodes released (common-anode, active-low enables).
   localparam logic [3:0] AN_OFF = 4'b1111;

   // Scan slot order; slot n drives anode bit n (bit 0 = rightmost digit).
   localparam logic [1:0] DIG_SEC_ONES = 2'd0;
   localparam logic [1:0] DIG_SEC_TENS = 2'd1;
   localparam logic [1:0] DIG_MIN_ONES = 2'd2;
   localparam logic [1:0] DIG_MIN_TENS = 2'd3;

   // One registered display word: anodes, segments, decimal point.
   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
   } disp_t;

   localparam disp_t DISP_OFF = '{an: AN_OFF, seg: SEG_BLANK, dp: 1'b1};

   // Active-low anode vector with a single 0 at the given slot.
   function automatic logic [3:0] an_select(input logic [1:0] idx);
      logic [3:0] an_v;
      an_v      = AN_OFF;
      an_v[idx] = 1'b0;
      return an_v;
   endfunction

endpackage

// File: rtl/seg7_scan_driver_bcd_to_seg7.sv
// ---------------------------------------------------------------------------
// bcd_to_seg7
//   Purely combinational BCD to active-low 7-segment decoder.
//   Codes 10..15 are not digits and decode to a dark glyph.
// Ports:
//   bcd  in  4  digit code
//   seg  out 7  segments {g,f,e,d,c,b,a}, active-low
// ---------------------------------------------------------------------------
module bcd_to_seg7
   import seg7_scan_driver_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
//   Time-multiplexed driver for a 4-digit common-anode 7-segment display
//   showing MM.SS from the stopwatch BCD outputs. Each digit owns a slot of
//   REFRESH_DIV clocks; the first BLANK_CYCLES of every slot keep all anodes
//   off so the previous digit's segments do not ghost onto the next one.
//   The decimal point of the minutes-ones digit separates MM from SS. In
//   adjust mode the selected field blinks at 1 Hz (toggled by clk_2hz).
// Ports:
//   clk_100mhz    in  1  system clock, rising edge
//   rst           in  1  synchronous active-high reset
//   clk_2hz       in  1  one-cycle blink pacing pulse
//   bcd_min_tens  in  4  minutes tens digit
//   bcd_min_ones  in  4  minutes ones digit
//   bcd_sec_tens  in  4  seconds tens digit
//   bcd_sec_ones  in  4  seconds ones digit
//   is_adj        in  1  adjust mode active
//   is_sel_sec    in  1  1 = seconds field selected, 0 = minutes
//   an            out 4  anode enables, active-low, an[0] = seconds ones
//   seg           out 7  segments {g,f,e,d,c,b,a}, active-low
//   dp            out 1  decimal point, active-low
// ---------------------------------------------------------------------------
module seg7_scan_driver
   import seg7_scan_driver_pkg::*;
#(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000
)(
   input  logic       clk_100mhz,
   input  logic       rst,
   input  logic       clk_2hz,
   input  logic [3:0] bcd_min_tens,
   input  logic [3:0] bcd_min_ones,
   input  logic [3:0] bcd_sec_tens,
   input  logic [3:0] bcd_sec_ones,
   input  logic       is_adj,
   input  logic       is_sel_sec,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int              CNT_W     = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

   logic [CNT_W-1:0] cnt;
   logic [1:0]       idx;
   logic             blink_phase;
   logic [3:0]       cur_digit;

   logic [3:0]       live_digit;
   logic [3:0]       show_digit;
   logic [6:0]       glyph;
   logic             sel_field;
   logic             hide;
   disp_t            disp_nxt;
   disp_t            disp_q;

   // Digit feeding the current slot.
   always_comb begin
      live_digit = bcd_sec_ones;
      case (idx)
         DIG_SEC_ONES: live_digit = bcd_sec_ones;
         DIG_SEC_TENS: live_digit = bcd_sec_tens;
         DIG_MIN_ONES: live_digit = bcd_min_ones;
         DIG_MIN_TENS: live_digit = bcd_min_tens;
         default:      live_digit = bcd_sec_ones;
      endcase
   end

   // On the snapshot cycle cur_digit is only being loaded, so decode the
   // value it is about to take. This keeps the glyph correct even with no
   // blank interval; otherwise the held snapshot is shown all slot long.
   assign show_digit = (cnt == '0) ? live_digit : cur_digit;

   bcd_to_seg7 u_dec (
      .bcd (show_digit),
      .seg (glyph)
   );

   // Slots 0-1 are the seconds field, slots 2-3 the minutes field.
   assign sel_field = is_sel_sec ? (idx <= DIG_SEC_TENS) : (idx >= DIG_MIN_ONES);
   assign hide      = is_adj & blink_phase & sel_field;

   // Next display word. A hidden digit keeps its anode driven so the
   // display brightness does not shift while blinking.
   always_comb begin
      disp_nxt = DISP_OFF;
      if (cnt >= CNT_BLANK) begin
         disp_nxt.an = an_select(idx);
         if (!hide) begin
            disp_nxt.seg = glyph;
            disp_nxt.dp  = (idx != DIG_MIN_ONES);
         end
      end
   end

   always_ff @(posedge clk_100mhz) begin
      if (rst) begin
         cnt         <= '0;
         idx         <= DIG_SEC_ONES;
         blink_phase <= 1'b0;
         cur_digit   <= 4'd0;
         disp_q      <= DISP_OFF;
      end else begin
         if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= idx + 2'd1;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end

         // Digit is frozen for the whole slot; mid-slot input changes wait
         // for the digit's next turn.
         if (cnt == '0)
            cur_digit <= live_digit;

         // Leaving adjust mode parks the phase at "visible".
         blink_phase <= is_adj & (blink_phase ^ clk_2hz);

         disp_q <= disp_nxt;
      end
   end

   assign an  = disp_q.an;
   assign seg = disp_q.seg;
   assign dp  = disp_q.dp;

endmodule
